// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, port indices and the
// round-robin/lock winner selection.
package dmem_arbiter_pkg;

  localparam int unsigned DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Picks the winner among eligible ports; a held lock favours the loader.
  function automatic logic pick_port(input logic c0, input logic c1,
                                     input logic ptr, input logic lock_hold);
    if (c0 && c1) begin
      return lock_hold ? PORT1 : ptr;
    end
    return c1 ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-ported data memory: pipeline (port 0) and
// debug/boot loader (port 1), round-robin with a bounded loader lock.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LOCK = 8,
  parameter int unsigned LOCK_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [LOCK_W-1:0] LockMax = LOCK_W'(MAX_LOCK);

  state_e              state_q, state_d;
  logic                winner_q, winner_d;
  logic                ptr_q, ptr_d;
  logic [LOCK_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                mwr_q, mwr_d;
  logic                mrd_q, mrd_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                busy_q, busy_d;

  logic                lock_hold;
  logic                cand0, cand1;
  logic                grant_port;

  // Next-state, grant and strobe logic.
  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    ptr_d      = ptr_q;
    cnt_d      = lock1 ? cnt_q : '0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    mwr_d      = 1'b0;
    mrd_d      = 1'b0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    cand0      = 1'b0;
    cand1      = 1'b0;
    grant_port = PORT0;
    lock_hold  = lock1 && (cnt_q < LockMax);

    unique case (state_q)
      ST_IDLE: begin
        cand0 = req0;
        cand1 = req1;
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (winner_q == PORT1) begin
          ack1_d = 1'b1;
          if (mrd_q) rdata1_d = mem_read_data;
        end else begin
          ack0_d = 1'b1;
          if (mrd_q) rdata0_d = mem_read_data;
        end
      end
      ST_RESP: begin
        // The acked port's request is the one just completed; a locked
        // loader keeps ownership by idling one cycle instead of yielding.
        state_d = ST_IDLE;
        cand0   = req0 && (winner_q == PORT1) && !lock_hold;
        cand1   = req1 && (winner_q == PORT0);
      end
      default: state_d = ST_IDLE;
    endcase

    if (cand0 || cand1) begin
      grant_port = pick_port(cand0, cand1, ptr_q, lock_hold);
      state_d    = ST_ACCESS;
      winner_d   = grant_port;
      ptr_d      = ~grant_port;
      addr_d     = (grant_port == PORT1) ? addr1 : addr0;
      wdata_d    = (grant_port == PORT1) ? wdata1 : wdata0;
      mwr_d      = (grant_port == PORT1) ? we1 : we0;
      mrd_d      = (grant_port == PORT1) ? !we1 : !we0;
      if (grant_port == PORT1 && lock1) begin
        cnt_d = (cnt_q == LockMax) ? cnt_q : cnt_q + LOCK_W'(1);
      end else begin
        cnt_d = '0;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      winner_q <= PORT0;
      ptr_q    <= PORT0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      mwr_q    <= 1'b0;
      mrd_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      mwr_q    <= mwr_d;
      mrd_q    <= mrd_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
    end
  end

  assign ack0           = ack0_q;
  assign ack1           = ack1_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;
  assign busy           = busy_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_MemWrite   = mwr_q;
  assign mem_MemRead    = mrd_q;

endmodule
